solver_io: RTL and testbench

Host-side transaction front end for the expression solver. It accepts one operand over a valid/ready input channel and drives the operand, a soft reset and a start pulse to the solver control/datapath pair. It then waits for the solver's completed flag, captures the result, and presents it on a valid/ready output channel. The solver holds completed high until it is reset, so this block re-arms it with a one-cycle soft reset before every launch.

---
 rtl/solver_io_if.sv | 32 +++
 rtl/solver_io.sv | 89 ++++++++
 tb/tb_solver_io.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/solver_io_if.sv
// Handshake and solver-control bundle for solver_io.
// master = solver_io side, slave = host/solver side.
interface solver_io_if #(
  parameter int WIDTH  = 8,
  parameter int RWIDTH = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_x;
  logic              out_valid;
  logic              out_ready;
  logic [RWIDTH-1:0] out_result;
  logic              out_timeout;
  logic [7:0]        out_cycles;
  logic              solver_rst;
  logic              solver_start;
  logic [WIDTH-1:0]  solver_x;
  logic              solver_completed;
  logic [RWIDTH-1:0] solver_result;

  modport master (
    input  in_valid, in_x, out_ready, solver_completed, solver_result,
    output in_ready, out_valid, out_result, out_timeout, out_cycles,
           solver_rst, solver_start, solver_x
  );

  modport slave (
    output in_valid, in_x, out_ready, solver_completed, solver_result,
    input  in_ready, out_valid, out_result, out_timeout, out_cycles,
           solver_rst, solver_start, solver_x
  );
endinterface

// File: rtl/solver_io.sv
// Host-side front end for the expression solver: accept operand, re-arm, launch, capture.
// SOLVER_IO_TIMEOUT_EN enables the TIMEOUT abort path in WAIT.
module solver_io #(
  parameter int WIDTH   = 8,
  parameter int RWIDTH  = 16,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  solver_io_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, HOLD} state_t;

  localparam logic [7:0] TO_K = 8'(TIMEOUT);

  state_t            state, state_nxt;
  logic [7:0]        count, count_inc;
  logic              timeout_hit;
  logic [RWIDTH-1:0] result_q;
  logic              timeout_q;
  logic [7:0]        cycles_q;
  logic [WIDTH-1:0]  x_q;

  assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

`ifdef SOLVER_IO_TIMEOUT_EN
  assign timeout_hit = (count_inc == TO_K);
`else
  // Never fires; the compare keeps TIMEOUT referenced in this build.
  assign timeout_hit = 1'b0 & (count_inc == TO_K);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (bus.solver_completed || timeout_hit) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      x_q       <= '0;
    end else begin
      unique case (state)
        IDLE:   if (bus.in_valid) x_q <= bus.in_x;
        LAUNCH: count <= '0;
        WAIT: begin
          count <= count_inc;
          // Completion takes priority over a coincident timeout.
          if (bus.solver_completed) begin
            result_q  <= bus.solver_result;
            timeout_q <= 1'b0;
            cycles_q  <= count_inc;
          end else if (timeout_hit) begin
            result_q  <= '0;
            timeout_q <= 1'b1;
            cycles_q  <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == HOLD);
  assign bus.solver_rst   = rst | (state == CLEAR);
  assign bus.solver_start = (state == LAUNCH);
  assign bus.solver_x     = x_q;
  assign bus.out_result   = result_q;
  assign bus.out_timeout  = timeout_q;
  assign bus.out_cycles   = cycles_q;

endmodule

// File: tb/tb_solver_io.sv
// Scoreboard bench for solver_io: directed transactions with a cycle-driven solver model.
module tb_solver_io;

  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  solver_io_if #(.WIDTH(8), .RWIDTH(16)) bus ();

  solver_io #(.WIDTH(8), .RWIDTH(16), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [15:0] r;
    logic        t;
    logic [7:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result",  32'(bus.out_result),  32'(e.r));
        chk("out_timeout", 32'(bus.out_timeout), 32'(e.t));
        chk("out_cycles",  32'(bus.out_cycles),  32'(e.c));
      end
    end
  end

  // k = WAIT cycle in which the solver model raises completed (0 = never).
  task automatic do_txn(input logic [7:0] x, input int k, input logic [15:0] res,
                        input bit stale, input int bp, input logic [7:0] nx);
    int   e;
    int   acc;
    bit   to;
    exp_t ex;
`ifdef SOLVER_IO_TIMEOUT_EN
    to = (k == 0) || (k > TO);
`else
    to = 1'b0;
`endif
    e    = to ? TO : k;
    ex.r = to ? 16'h0 : res;
    ex.t = to;
    ex.c = (e > 255) ? 8'hFF : 8'(e);
    exp_q.push_back(ex);

    bus.out_ready = (bp == 0);
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc = i;
      tick();
    end
    if (acc < 0) begin
      chk("accept_bound", 32'(acc), 32'd0);
      return;
    end
    chk("accept_latency", 32'(acc), 32'd0);
    bus.in_valid = 1'b0;

    // CLEAR
    @(negedge clk);
    chk("clear_solver_rst", 32'(bus.solver_rst), 32'd1);
    chk("clear_start", 32'(bus.solver_start), 32'd0);
    chk("solver_x", 32'(bus.solver_x), 32'(x));
    tick();
    if (!stale) bus.solver_completed = 1'b0;

    // LAUNCH
    @(negedge clk);
    chk("launch_start", 32'(bus.solver_start), 32'd1);
    chk("launch_solver_rst", 32'(bus.solver_rst), 32'd0);
    tick();
    bus.solver_completed = 1'b0;
    bus.solver_result    = 16'h0;

    for (int j = 1; j <= e; j++) begin
      if (j == k) begin
        bus.solver_completed = 1'b1;
        bus.solver_result    = res;
      end
      @(negedge clk);
      chk("wait_no_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end

    // HOLD, optionally backpressured with a new operand offered
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = nx;
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", 32'(bus.out_result), 32'(ex.r));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_solver_x", 32'(bus.solver_x), 32'(x));
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    tick();
  endtask

  initial begin
    rst                  = 1'b1;
    bus.in_valid         = 1'b0;
    bus.in_x             = 8'h00;
    bus.out_ready        = 1'b1;
    bus.solver_completed = 1'b0;
    bus.solver_result    = 16'h0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_solver_rst", 32'(bus.solver_rst), 32'd1);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_start", 32'(bus.solver_start), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_out_timeout", 32'(bus.out_timeout), 32'd0);
    chk("rst_out_cycles", 32'(bus.out_cycles), 32'd0);
    chk("rst_solver_x", 32'(bus.solver_x), 32'd0);
    chk("rst_solver_rst_low", 32'(bus.solver_rst), 32'd0);
    tick();

    do_txn(8'h03, 8, 16'h0021, 1'b0, 5, 8'h07);
    do_txn(8'h07, 3, 16'h0077, 1'b0, 0, 8'h00);
`ifdef SOLVER_IO_TIMEOUT_EN
    do_txn(8'h11, 0, 16'h0BAD, 1'b0, 0, 8'h00);
`else
    do_txn(8'h11, 301, 16'h0BAD, 1'b0, 0, 8'h00);
`endif
    do_txn(8'h22, TO, 16'h1234, 1'b1, 0, 8'h00);
    do_txn(8'h05, 2, 16'h0055, 1'b1, 0, 8'h00);

    // Abort with rst in WAIT cycle 4, the cycle the solver also finishes
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h44;
    @(negedge clk);
    chk("abort_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.solver_completed = 1'b0;
      tick();
    end
    rst                  = 1'b1;
    bus.solver_completed = 1'b1;
    bus.solver_result    = 16'hBEEF;
    @(negedge clk);
    chk("abort_solver_rst", 32'(bus.solver_rst), 32'd1);
    tick();
    @(negedge clk);
    chk("abort_idle", 32'(bus.in_ready), 32'd1);
    chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_solver_rst2", 32'(bus.solver_rst), 32'd1);
    chk("abort_result_clr", 32'(bus.out_result), 32'd0);
    chk("abort_cycles_clr", 32'(bus.out_cycles), 32'd0);
    tick();
    rst                  = 1'b0;
    bus.solver_completed = 1'b0;
    @(negedge clk);
    chk("abort_after_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_after_rst", 32'(bus.solver_rst), 32'd0);
    tick();

    do_txn(8'h09, 1, 16'h0099, 1'b0, 0, 8'h00);

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
